// File: rtl/acl_frame_fifo.sv
// Store-and-forward ACL frame FIFO: commits or discards whole frames, forwards only committed ones.
// Latency: tlast accepted at edge N -> counters update at N, first output beat valid after edge N+2.
// Backpressure: never stalls the receive side (tready=1 out of reset); overflowing frames are dropped.
//
// Ports:
//   clk, rst                          single clock, synchronous active-high reset
//   i_rxd_tdata/tvalid/tlast          AXI-Stream receive beat (o_rxd_tready returned)
//   i_fifo_invalid                    ACL verdict, sampled on the accepted tlast beat (1 = discard)
//   o_txd_tdata/tvalid/tlast          AXI-Stream transmit, first-word-fall-through (i_txd_tready in)
//   o_wr_cnt                          committed words not yet handed off downstream
//   o_frame_cnt                       committed frames not yet fully output (saturating)
//   o_overflow                        one-cycle pulse when a frame is dropped for lack of space
//   o_drop_cnt                        present only with ACL_DROP_STATS_EN: saturating count of
//                                     frames discarded by verdict or overflow
module acl_frame_fifo #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 9,
    parameter int FRAME_CNT_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      i_rxd_tdata,
    input  logic                       i_rxd_tvalid,
    input  logic                       i_rxd_tlast,
    input  logic                       i_fifo_invalid,
    output logic                       o_rxd_tready,
    output logic [DATA_WIDTH-1:0]      o_txd_tdata,
    output logic                       o_txd_tvalid,
    output logic                       o_txd_tlast,
    input  logic                       i_txd_tready,
    output logic [ADDR_WIDTH:0]        o_wr_cnt,
    output logic [FRAME_CNT_WIDTH-1:0] o_frame_cnt,
    output logic                       o_overflow
`ifdef ACL_DROP_STATS_EN
    ,
    output logic [31:0]                o_drop_cnt
`endif
);

    localparam int                        DEPTH    = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]       L_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [FRAME_CNT_WIDTH-1:0] L_FC_MAX = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    // Storage: each word carries its tlast flag above the data.
    logic [DATA_WIDTH:0]        r_mem [0:DEPTH-1];

    logic [1:0]                 r_state;
    logic [ADDR_WIDTH:0]        r_wr_spec;     // next speculative write slot
    logic [ADDR_WIDTH:0]        r_wr_commit;   // end of last committed frame
    logic [ADDR_WIDTH:0]        r_rd_addr;     // next RAM word to fetch into the read pipeline
    logic [ADDR_WIDTH:0]        r_rd;          // words handed off on the output handshake
    logic                       r_rxd_tready;
    logic                       r_overflow;
    logic [FRAME_CNT_WIDTH-1:0] r_frame_cnt;

    // Read pipeline: registered RAM output, then the FWFT output register.
    logic [DATA_WIDTH:0]        r_ram_q;
    logic                       r_ram_vld;
    logic [DATA_WIDTH-1:0]      r_txd_tdata;
    logic                       r_txd_tlast;
    logic                       r_txd_tvalid;

    logic                       w_rx_acc;
    logic                       w_full;
    logic                       w_overflow;
    logic                       w_wr_en;
    logic                       w_commit;
    logic                       w_deny;
    logic                       w_tx_hs;
    logic                       w_out_load;
    logic                       w_rd_issue;
    logic                       w_fc_dec;

    assign w_rx_acc   = i_rxd_tvalid & r_rxd_tready;
    // Space is measured against handed-off words, so anything still sitting in the
    // read pipeline keeps its slot reserved; the handshake of this cycle is not credited.
    assign w_full     = ((r_wr_spec - r_rd) == L_DEPTH);
    assign w_overflow = w_rx_acc & (r_state != S_DROP) & w_full;
    assign w_wr_en    = w_rx_acc & (r_state != S_DROP) & ~w_full;
    assign w_commit   = w_wr_en & i_rxd_tlast & ~i_fifo_invalid;
    assign w_deny     = w_wr_en & i_rxd_tlast & i_fifo_invalid;

    assign w_tx_hs    = r_txd_tvalid & i_txd_tready;
    assign w_out_load = r_ram_vld & (~r_txd_tvalid | i_txd_tready);
    assign w_rd_issue = (r_rd_addr != r_wr_commit) & (~r_ram_vld | w_out_load);
    assign w_fc_dec   = w_tx_hs & r_txd_tlast;

    // RAM array and its registered read port; the read never targets the slot being
    // written because reads stay below wr_commit and writes stop at full.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_spec[ADDR_WIDTH-1:0]] <= {i_rxd_tlast, i_rxd_tdata};
        end
        if (w_rd_issue) begin
            r_ram_q <= r_mem[r_rd_addr[ADDR_WIDTH-1:0]];
        end
    end

    // Write side state machine and pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_spec    <= '0;
            r_wr_commit  <= '0;
            r_rxd_tready <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_rxd_tready <= 1'b1;
            r_overflow   <= w_overflow;
            case (r_state)
                S_IDLE, S_WRITE: begin
                    if (w_rx_acc) begin
                        if (w_full) begin
                            // Abandon the partial frame; swallow the rest of it.
                            r_wr_spec <= r_wr_commit;
                            r_state   <= i_rxd_tlast ? S_IDLE : S_DROP;
                        end else if (i_rxd_tlast) begin
                            if (i_fifo_invalid) begin
                                r_wr_spec <= r_wr_commit;
                            end else begin
                                r_wr_spec   <= r_wr_spec + 1'b1;
                                r_wr_commit <= r_wr_spec + 1'b1;
                            end
                            r_state <= S_IDLE;
                        end else begin
                            r_wr_spec <= r_wr_spec + 1'b1;
                            r_state   <= S_WRITE;
                        end
                    end
                end
                S_DROP: begin
                    if (w_rx_acc && i_rxd_tlast) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read side: fetch pipeline and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_addr    <= '0;
            r_rd         <= '0;
            r_ram_vld    <= 1'b0;
            r_txd_tdata  <= '0;
            r_txd_tlast  <= 1'b0;
            r_txd_tvalid <= 1'b0;
        end else begin
            if (w_rd_issue) begin
                r_rd_addr <= r_rd_addr + 1'b1;
                r_ram_vld <= 1'b1;
            end else if (w_out_load) begin
                r_ram_vld <= 1'b0;
            end

            if (w_out_load) begin
                r_txd_tvalid <= 1'b1;
                r_txd_tlast  <= r_ram_q[DATA_WIDTH];
                r_txd_tdata  <= r_ram_q[DATA_WIDTH-1:0];
            end else if (w_tx_hs) begin
                r_txd_tvalid <= 1'b0;
            end

            if (w_tx_hs) begin
                r_rd <= r_rd + 1'b1;
            end
        end
    end

    // Committed-frame counter; a commit and a tlast handoff in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_commit && !w_fc_dec) begin
            if (r_frame_cnt != L_FC_MAX) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end else if (w_fc_dec && !w_commit) begin
            if (r_frame_cnt != '0) begin
                r_frame_cnt <= r_frame_cnt - 1'b1;
            end
        end
    end

`ifdef ACL_DROP_STATS_EN
    logic [31:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if ((w_overflow || w_deny) && (r_drop_cnt != 32'hFFFF_FFFF)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

    assign o_rxd_tready = r_rxd_tready;
    assign o_txd_tdata  = r_txd_tdata;
    assign o_txd_tvalid = r_txd_tvalid;
    assign o_txd_tlast  = r_txd_tlast;
    // Committed words minus handed-off words: grows by the frame length at commit,
    // shrinks by one per output handshake.
    assign o_wr_cnt     = r_wr_commit - r_rd;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_overflow   = r_overflow;

endmodule

// File: doc/acl_frame_fifo.md
# acl_frame_fifo

Parametrised store-and-forward frame FIFO for the ACL ingress path, successor to the single-width word FIFO. Accepts AXI-Stream receive beats, holds each frame speculatively until its last beat and the ACL verdict arrive, then commits or discards the whole frame. Only committed frames are presented on an AXI-Stream master output, so downstream logic never sees a denied or truncated frame.

## Interface
- DATA_WIDTH, 32, stream data width in bits
- ADDR_WIDTH, 9, log2 of RAM depth; DEPTH = 2**ADDR_WIDTH words
- FRAME_CNT_WIDTH, 6, width of committed-frame counter
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, synchronous and active-high
- i_rxd_tdata  in  DATA_WIDTH  receive data
- i_rxd_tvalid  in  1  receive beat valid
- i_rxd_tlast  in  1  last beat of frame
- i_fifo_invalid  in  1  ACL verdict; sampled only on the accepted tlast beat; 1 = discard frame
- o_rxd_tready  out  1  receive ready
- o_txd_tdata  out  DATA_WIDTH  transmit data
- o_txd_tvalid  out  1  transmit valid
- o_txd_tlast  out  1  transmit last
- i_txd_tready  in  1  transmit ready from downstream
- o_wr_cnt  out  ADDR_WIDTH+1  committed words not yet handed off on the output handshake
- o_frame_cnt  out  FRAME_CNT_WIDTH  committed frames not yet fully output
- o_overflow  out  1  one-cycle pulse when a frame is discarded for lack of space

## Operation
- RAM word = {tlast, tdata}; DATA_WIDTH+1 bits, one write port, one read port.
- Pointers: wr_spec, wr_commit, rd; all ADDR_WIDTH+1 bits, MSB used for wrap/full detection.
- Write states: IDLE, WRITE, DROP.
  - IDLE -> WRITE on the first accepted beat that is not tlast; a single-beat frame is written and resolved in IDLE.
  - WRITE: each beat is written at wr_spec, then wr_spec increments.
  - Accepted tlast beat with i_fifo_invalid=0 -> wr_commit <= wr_spec+1; frame counter increments; -> IDLE.
  - Accepted tlast beat with i_fifo_invalid=1 -> wr_spec <= wr_commit; -> IDLE; no o_overflow.
  - Beat arrives while speculatively full (wr_spec - rd == DEPTH) -> wr_spec <= wr_commit; o_overflow pulse; -> DROP, or -> IDLE if that beat is tlast.
  - DROP: beats are consumed and not written; -> IDLE on tlast. The verdict is ignored.
- o_rxd_tready = 1 in all write states; back-pressure is never applied upstream, and overflow drops the frame.
- Read side: first-word-fall-through output register; a RAM read is issued when rd != wr_commit and the output register is empty or is being consumed.
- Output handshake: a beat transfers when o_txd_tvalid && i_txd_tready; data and tlast are held stable while valid && !ready.
- o_wr_cnt increases by the frame length at commit and decreases by 1 per output handshake; simultaneous events apply net.
- o_frame_cnt increases at commit and decreases on the output handshake with tlast=1; simultaneous events give net 0. It saturates at its maximum and does not wrap.

## Timing
- Reset: all pointers, counters, and state return to 0/IDLE. After reset: o_rxd_tready=0, o_txd_tvalid=0, o_txd_tdata=0, o_txd_tlast=0, o_wr_cnt=0, o_frame_cnt=0, o_overflow=0.
- o_rxd_tready goes to 1 on the first clock edge with rst=0.
- Reset mid-frame: the partial frame and all stored frames are lost, and the output register is cleared.
- Commit latency: tlast accepted at edge N -> o_wr_cnt and o_frame_cnt update at N; the first beat's o_txd_tvalid is asserted after edge N+2.
- Sustained output: 1 beat/cycle while i_txd_tready=1 and committed data remains.
- Full-and-read in the same cycle: the full check uses rd before the current read.

## Configuration
- ACL_DROP_STATS_EN defined: adds output o_drop_cnt [31:0], reset 0. It increments once per frame discarded by verdict or overflow and saturates at 32'hFFFFFFFF.
- Not defined: the port and counter are absent, and all other behaviour is identical.

## Test plan
Bench settings: DATA_WIDTH=32, ADDR_WIDTH=4 (DEPTH 16), clk period 6.4 ns.
- Permit frame: write 5 beats 0x1..0x5 with verdict 0 and tready=1 -> output is 0x1..0x5 with tlast on 0x5; o_wr_cnt peaks at 5; o_frame_cnt goes 1 -> 0.
- Deny frame: write 6 beats with verdict 1, then a 3-beat permit frame -> only the 3-beat frame is output; o_drop_cnt=1 when the macro is defined.
- Overflow: i_txd_tready=0; write a 10-beat permit frame, then a 10-beat frame -> o_overflow pulses once on the 7th beat of the second frame; o_wr_cnt=10; after release, only the first frame is output.
- Back-pressure: toggle i_txd_tready every cycle over a 4-beat frame -> no beat lost or duplicated; data is held stable while stalled.
- Reset mid-frame: assert rst after 3 of 8 beats -> all outputs return to their reset values; the next 2-beat frame passes intact.
- Wrap-around: 40 consecutive 7-beat permit frames with tready=1 -> all 280 beats are output in order, and o_wr_cnt never exceeds 16.
